// File: rtl/pzvip_tilelink_ul_memory.sv
// TileLink-UL slave memory: accepts Get/PutFull/PutPartial on A and
// returns in-order AccessAck/AccessAckData on D through a response FIFO.
module pzvip_tilelink_ul_memory #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 64,
  parameter int SOURCE_WIDTH  = 8,
  parameter int SIZE_WIDTH    = 3,
  parameter longint BASE_ADDRESS = 0,
  parameter int WORDS         = 256,
  parameter int RSP_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [2:0]                    a_opcode,
  input  logic [2:0]                    a_param,
  input  logic [SIZE_WIDTH-1:0]         a_size,
  input  logic [SOURCE_WIDTH-1:0]       a_source,
  input  logic [ADDRESS_WIDTH-1:0]      a_address,
  input  logic [DATA_WIDTH/8-1:0]       a_mask,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic                          a_corrupt,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [2:0]                    d_opcode,
  output logic [1:0]                    d_param,
  output logic [SIZE_WIDTH-1:0]         d_size,
  output logic [SOURCE_WIDTH-1:0]       d_source,
  output logic                          d_sink,
  output logic                          d_denied,
  output logic [DATA_WIDTH-1:0]         d_data,
  output logic                          d_corrupt,
  output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding
);

  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(DATA_BYTES);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [2:0]              opcode;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    denied;
    logic [DATA_WIDTH-1:0]   data;
    logic                    corrupt;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  rsp_t                  fifo [RSP_DEPTH];
  rsp_t                  rsp;
  rsp_t                  head;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          active;
  logic          full;
  logic          push;
  logic          pop;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [ADDRESS_WIDTH-1:0] align_mask;
  logic [IW-1:0]            index;
  logic                     addr_bad;
  logic                     write_en;
  logic                     is_get;
  logic                     is_put;
  logic                     is_atomic;
  logic                     is_hint;
  logic                     unused;

  assign full    = (count == CW'(RSP_DEPTH));
  assign a_ready = active && !full;
  assign push    = a_valid && a_ready;
  assign d_valid = (count != '0);
  assign pop     = d_valid && d_ready;

  assign offset     = a_address - ADDRESS_WIDTH'(BASE_ADDRESS);
  assign index      = offset[SHIFT +: IW];
  assign align_mask = (ADDRESS_WIDTH'(1) << a_size) - ADDRESS_WIDTH'(1);

  assign addr_bad = (a_address < ADDRESS_WIDTH'(BASE_ADDRESS))
                 || ((offset >> SHIFT) >= ADDRESS_WIDTH'(WORDS))
                 || (a_size > SIZE_WIDTH'(SHIFT))
                 || (|(a_address & align_mask));

  assign is_get    = (a_opcode == 3'd4);
  assign is_put    = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign is_atomic = (a_opcode == 3'd2) || (a_opcode == 3'd3);
  assign is_hint   = (a_opcode == 3'd5);

  always_comb begin
    rsp         = '0;
    rsp.size    = a_size;
    rsp.source  = a_source;
    rsp.denied  = 1'b1;
    write_en    = 1'b0;
    unique case (1'b1)
      is_get: begin
        rsp.opcode  = 3'd1;
        rsp.denied  = addr_bad;
        rsp.corrupt = addr_bad;
        rsp.data    = addr_bad ? '0 : mem[index];
      end
      is_put: begin
        rsp.opcode = 3'd0;
        rsp.denied = addr_bad;
        write_en   = !addr_bad && !a_corrupt;
      end
      is_atomic: begin
        rsp.opcode  = 3'd1;
        rsp.corrupt = 1'b1;
      end
      is_hint: begin
        rsp.opcode = 3'd2;
      end
      default: begin
        rsp.opcode = 3'd0;
      end
    endcase
  end

  // Array is intentionally not reset so contents survive reset_n.
  always_ff @(posedge clock) begin
    if (push && write_en) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (a_mask[i]) mem[index][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= rsp;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      active <= 1'b1;
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = fifo[rd_ptr];
  assign d_opcode    = head.opcode;
  assign d_param     = 2'd0;
  assign d_size      = head.size;
  assign d_source    = head.source;
  assign d_sink      = 1'b0;
  assign d_denied    = head.denied;
  assign d_data      = head.data;
  assign d_corrupt   = head.corrupt;
  assign outstanding = count;

  assign unused = ^a_param;

endmodule

// File: tb/tb_pzvip_tilelink_ul_memory.sv
// Directed bench for pzvip_tilelink_ul_memory with hand-computed
// expected responses.
module tb_pzvip_tilelink_ul_memory;

  logic        clock;
  logic        reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [7:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;
  logic [2:0]  outstanding;

  int n_cmp;
  int n_err;

  localparam logic [63:0] V10 = 64'h1122334455667788;
  localparam logic [63:0] V18 = 64'h00000000FFFFFFFF;
  localparam logic [63:0] V20 = 64'hA5A5A5A55A5A5A5A;
  localparam logic [63:0] V28 = 64'h0123456789ABCDEF;
  localparam logic [63:0] V30 = 64'hCAFEF00DDEADBEEF;

  pzvip_tilelink_ul_memory dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_opcode    (a_opcode),
    .a_param     (a_param),
    .a_size      (a_size),
    .a_source    (a_source),
    .a_address   (a_address),
    .a_mask      (a_mask),
    .a_data      (a_data),
    .a_corrupt   (a_corrupt),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_param     (d_param),
    .d_size      (d_size),
    .d_source    (d_source),
    .d_sink      (d_sink),
    .d_denied    (d_denied),
    .d_data      (d_data),
    .d_corrupt   (d_corrupt),
    .outstanding (outstanding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] sz,
                       input logic [7:0] src, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [63:0] data,
                       input logic cor);
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = cor;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] sz,
                      input logic [7:0] src, input logic [31:0] addr,
                      input logic [7:0] mask, input logic [63:0] data,
                      input logic cor);
    bit ok;
    ok = 0;
    set_a(op, sz, src, addr, mask, data, cor);
    a_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (a_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("a_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clock);
      #1;
    end
    a_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [2:0] op,
                      input logic [7:0] src, input logic den,
                      input logic cor, input logic [63:0] data);
    bit ok;
    ok = 0;
    d_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (d_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
    else begin
      chk({tag, "_op"}, 64'(d_opcode), 64'(op));
      chk({tag, "_src"}, 64'(d_source), 64'(src));
      chk({tag, "_den"}, 64'(d_denied), 64'(den));
      chk({tag, "_cor"}, 64'(d_corrupt), 64'(cor));
      chk({tag, "_data"}, d_data, data);
      @(posedge clock);
      #1;
    end
    d_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit stale;
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    a_valid = 1'b0;
    a_param = 3'd0;
    d_ready = 1'b0;
    set_a(3'd0, 3'd3, 8'd0, 32'd0, 8'h00, 64'd0, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_a_ready_lo", 64'(a_ready), 64'd0);
    @(posedge clock);
    #1;
    chk("rel_a_ready_hi", 64'(a_ready), 64'd1);

    // Put then Get
    send(3'd0, 3'd3, 8'd3, 32'h10, 8'hFF, V10, 1'b0);
    send(3'd4, 3'd3, 8'd5, 32'h10, 8'hFF, 64'd0, 1'b0);
    chk("pg_outst", 64'(outstanding), 64'd2);
    recv("pg_ack", 3'd0, 8'd3, 1'b0, 1'b0, 64'd0);
    chk("pg_size", 64'(d_size), 64'd3);
    recv("pg_get", 3'd1, 8'd5, 1'b0, 1'b0, V10);

    // Partial write
    send(3'd0, 3'd3, 8'd6, 32'h18, 8'hFF, 64'd0, 1'b0);
    send(3'd1, 3'd3, 8'd7, 32'h18, 8'h0F, '1, 1'b0);
    send(3'd4, 3'd3, 8'd8, 32'h18, 8'hFF, 64'd0, 1'b0);
    recv("pp_ack0", 3'd0, 8'd6, 1'b0, 1'b0, 64'd0);
    recv("pp_ack1", 3'd0, 8'd7, 1'b0, 1'b0, 64'd0);
    recv("pp_get", 3'd1, 8'd8, 1'b0, 1'b0, V18);

    send(3'd0, 3'd3, 8'd9, 32'h20, 8'hFF, V20, 1'b0);
    send(3'd0, 3'd3, 8'd9, 32'h28, 8'hFF, V28, 1'b0);
    recv("pre_ack0", 3'd0, 8'd9, 1'b0, 1'b0, 64'd0);
    recv("pre_ack1", 3'd0, 8'd9, 1'b0, 1'b0, 64'd0);

    // Back-pressure
    send(3'd4, 3'd3, 8'd10, 32'h10, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd11, 32'h18, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd12, 32'h20, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd13, 32'h28, 8'hFF, 64'd0, 1'b0);
    set_a(3'd4, 3'd3, 8'd14, 32'h10, 8'hFF, 64'd0, 1'b0);
    a_valid = 1'b1;
    @(negedge clock);
    chk("bp_a_ready", 64'(a_ready), 64'd0);
    chk("bp_outst", 64'(outstanding), 64'd4);
    repeat (3) @(negedge clock);
    chk("bp_stall_outst", 64'(outstanding), 64'd4);
    chk("bp_stall_src", 64'(d_source), 64'd10);
    chk("bp_stall_data", d_data, V10);
    d_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_pop_outst", 64'(outstanding), 64'd3);
    chk("bp_pop_ready", 64'(a_ready), 64'd1);
    chk("bp_src11", 64'(d_source), 64'd11);
    chk("bp_data11", d_data, V18);
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    d_ready = 1'b0;
    chk("bp_pp_outst", 64'(outstanding), 64'd3);
    recv("bp_r12", 3'd1, 8'd12, 1'b0, 1'b0, V20);
    recv("bp_r13", 3'd1, 8'd13, 1'b0, 1'b0, V28);
    recv("bp_r14", 3'd1, 8'd14, 1'b0, 1'b0, V10);
    chk("bp_empty", 64'(outstanding), 64'd0);

    // Same-cycle push/pop at 2 entries
    send(3'd4, 3'd3, 8'd20, 32'h20, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd21, 32'h28, 8'hFF, 64'd0, 1'b0);
    chk("pp2_outst", 64'(outstanding), 64'd2);
    set_a(3'd4, 3'd3, 8'd22, 32'h18, 8'hFF, 64'd0, 1'b0);
    a_valid = 1'b1;
    d_ready = 1'b1;
    @(negedge clock);
    chk("pp2_src20", 64'(d_source), 64'd20);
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    d_ready = 1'b0;
    chk("pp2_outst_same", 64'(outstanding), 64'd2);
    recv("pp2_r21", 3'd1, 8'd21, 1'b0, 1'b0, V28);
    recv("pp2_r22", 3'd1, 8'd22, 1'b0, 1'b0, V18);

    // Denials
    send(3'd4, 3'd3, 8'd30, 32'h800, 8'hFF, 64'd0, 1'b0);
    recv("dn_range", 3'd1, 8'd30, 1'b1, 1'b1, 64'd0);
    send(3'd4, 3'd3, 8'd31, 32'h4, 8'hFF, 64'd0, 1'b0);
    recv("dn_align", 3'd1, 8'd31, 1'b1, 1'b1, 64'd0);
    send(3'd4, 3'd4, 8'd32, 32'h0, 8'hFF, 64'd0, 1'b0);
    recv("dn_size", 3'd1, 8'd32, 1'b1, 1'b1, 64'd0);
    send(3'd0, 3'd3, 8'd33, 32'h10, 8'hFF, 64'hDEADDEADDEADDEAD, 1'b1);
    recv("dn_cput", 3'd0, 8'd33, 1'b0, 1'b0, 64'd0);
    send(3'd4, 3'd3, 8'd34, 32'h10, 8'hFF, 64'd0, 1'b0);
    recv("dn_keep", 3'd1, 8'd34, 1'b0, 1'b0, V10);
    send(3'd5, 3'd3, 8'd35, 32'h10, 8'hFF, 64'd0, 1'b0);
    recv("dn_hint", 3'd2, 8'd35, 1'b1, 1'b0, 64'd0);
    send(3'd2, 3'd3, 8'd36, 32'h10, 8'hFF, 64'd0, 1'b0);
    recv("dn_arith", 3'd1, 8'd36, 1'b1, 1'b1, 64'd0);

    // Reset with responses pending
    send(3'd0, 3'd3, 8'd40, 32'h30, 8'hFF, V30, 1'b0);
    send(3'd4, 3'd3, 8'd41, 32'h10, 8'hFF, 64'd0, 1'b0);
    send(3'd4, 3'd3, 8'd42, 32'h18, 8'hFF, 64'd0, 1'b0);
    chk("mr_outst", 64'(outstanding), 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_d_valid", 64'(d_valid), 64'd0);
    chk("mr_outst0", 64'(outstanding), 64'd0);
    chk("mr_a_ready", 64'(a_ready), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    d_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clock);
      if (d_valid) stale = 1;
    end
    chk("mr_stale", 64'(stale), 64'd0);
    d_ready = 1'b0;
    @(posedge clock);
    #1;
    send(3'd4, 3'd3, 8'd43, 32'h30, 8'hFF, 64'd0, 1'b0);
    recv("mr_keep", 3'd1, 8'd43, 1'b0, 1'b0, V30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pzvip_tilelink_ul_memory.md
Name: pzvip_tilelink_ul_memory

Overview:
- Synthesizable TileLink-UL slave memory that terminates one A channel and produces the matching D channel.
- Sits directly downstream of a TileLink channel sender: consumes A requests (Get, PutFullData, PutPartialData) and returns AccessAck/AccessAckData in order through a response FIFO.
- Used as a lightweight memory model behind master agents and DUT master ports in block-level benches.

Parameters:
- ADDRESS_WIDTH, 32, width of a_address
- DATA_WIDTH, 64, data bus width in bits (power of 2, >= 8); DATA_BYTES = DATA_WIDTH/8
- SOURCE_WIDTH, 8, width of a_source/d_source
- SIZE_WIDTH, 3, width of a_size/d_size
- BASE_ADDRESS, 0, first byte address decoded by the memory
- WORDS, 256, memory depth in DATA_WIDTH words (power of 2)
- RSP_DEPTH, 4, response FIFO entries (>= 1)

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request ready
- a_opcode  in  3  A opcode
- a_param  in  3  A param (ignored)
- a_size  in  SIZE_WIDTH  log2 transfer bytes
- a_source  in  SOURCE_WIDTH  request ID
- a_address  in  ADDRESS_WIDTH  byte address
- a_mask  in  DATA_BYTES  byte lanes
- a_data  in  DATA_WIDTH  write data
- a_corrupt  in  1  write data corrupt
- d_valid  out  1  D response valid
- d_ready  in  1  D response ready
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SIZE_WIDTH  echoed a_size
- d_source  out  SOURCE_WIDTH  echoed a_source
- d_sink  out  1  always 0
- d_denied  out  1  request denied
- d_data  out  DATA_WIDTH  read data
- d_corrupt  out  1  read data corrupt
- outstanding  out  $clog2(RSP_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert by user): FIFO emptied, outstanding=0, d_valid=0, a_ready=0 while reset_n=0 and 1 from the first clock edge after release. Memory array is not reset; contents survive reset.
- a_ready = !full. It is registered-free and combinational on occupancy only, never on a_valid. A full FIFO does not accept even when d pops in the same cycle.
- Handshake: transfer on a_valid&&a_ready at posedge.
  - Request is decoded and its response pushed the same edge; d_valid rises the next cycle at the earliest (1-cycle latency).
  - Responses leave strictly in acceptance order.
- D rules: while d_valid=1 and d_ready=0, all d_* stay stable. Pop on d_valid&&d_ready. Push and pop in the same cycle keep occupancy unchanged.
- Decode:
  - index = (a_address-BASE_ADDRESS)>>log2(DATA_BYTES).
  - The request is denied if the address is below BASE_ADDRESS, index >= WORDS, a_size > log2(DATA_BYTES), or a_address is not aligned to 2^a_size.
- Get (4): AccessAckData. d_data = memory word read at acceptance, so a later Put never affects an earlier Get. If denied: d_data=0, d_denied=1, d_corrupt=1.
- PutFullData (0) / PutPartialData (1): AccessAck; bytes with a_mask[i]=1 are written at acceptance.
  - Writes are suppressed when denied or when a_corrupt=1; a_corrupt=1 still gives d_denied=0.
  - PutFullData mask is not checked.
- Other opcodes (2, 3, 5): denied, with no memory access. Opcodes 2 and 3 return AccessAckData with corrupt=1 and data 0; opcode 5 returns HintAck (d_opcode=2) with denied=1.
- d_corrupt=0 and d_data=0 for every AccessAck. d_size and d_source are always echoed.
- Reset mid-operation: pending responses are discarded; no response is emitted for them after release.

Test Plan:
- Put then Get: PutFullData addr 0x10, data 0x1122334455667788, mask 0xFF, source 3; Get 0x10, source 5 -> AccessAck src 3, then AccessAckData src 5, data 0x1122334455667788, denied=0.
- Partial write: preload 0, PutPartialData 0x18 mask 0x0F data all-F -> Get 0x18 returns 0x00000000FFFFFFFF.
- Back-pressure: d_ready=0, issue 5 Gets -> 4 accepted, a_ready=0 and outstanding=4. Then d_ready=1 -> responses in order with stable payload while stalled, and a_ready returns only after a pop.
- Denial: Get at BASE+WORDS*8 -> d_denied=1, d_corrupt=1, d_data=0. Misaligned Get 0x4 size 3 is likewise denied. Put with a_corrupt=1 leaves memory unchanged.
- Same-cycle push/pop with FIFO at 2 entries -> outstanding stays 2 and order is preserved.
- Reset with 3 responses pending -> d_valid=0 immediately; after release no stale response appears, and memory data written before reset is readable.
